// File: rtl/inst_pkg.sv
// Shared S-type definitions: opcodes, store widths and instruction field
// bit positions, common to the S-type encoder and decoder.
package inst_pkg;

  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_STORE_FP = 7'b0100111;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam int unsigned S_IMM_HI_MSB = 31;
  localparam int unsigned S_IMM_HI_LSB = 25;
  localparam int unsigned S_RS2_MSB    = 24;
  localparam int unsigned S_RS2_LSB    = 20;
  localparam int unsigned S_RS1_MSB    = 19;
  localparam int unsigned S_RS1_LSB    = 15;
  localparam int unsigned S_F3_MSB     = 14;
  localparam int unsigned S_F3_LSB     = 12;
  localparam int unsigned S_IMM_LO_MSB = 11;
  localparam int unsigned S_IMM_LO_LSB = 7;
  localparam int unsigned S_OP_MSB     = 6;
  localparam int unsigned S_OP_LSB     = 0;

  typedef enum logic [1:0] {
    REQ_INT,
    REQ_FP,
    REQ_ILLEGAL
  } req_kind_e;

  // Pack S-type fields into a 32-bit instruction word.
  function automatic logic [31:0] s_pack(
    input logic [11:0] imm,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [2:0]  funct3,
    input logic [6:0]  opcode
  );
    logic [31:0] w;
    w = '0;
    w[S_IMM_HI_MSB:S_IMM_HI_LSB] = imm[11:5];
    w[S_RS2_MSB:S_RS2_LSB]       = rs2;
    w[S_RS1_MSB:S_RS1_LSB]       = rs1;
    w[S_F3_MSB:S_F3_LSB]         = funct3;
    w[S_IMM_LO_MSB:S_IMM_LO_LSB] = imm[4:0];
    w[S_OP_MSB:S_OP_LSB]         = opcode;
    return w;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Parameterised synchronous FIFO (DEPTH must be a power of two, >= 2).
// Push is ignored when full, pop is ignored when empty.
module inst_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  // Occupancy next-state from the qualified push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  // Pointer and occupancy registers; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/inst_s_enc.sv
// Sequential S-type store instruction encoder with address tagging and an
// output FIFO. Optional macro INST_S_ENC_FSW_EN makes FSW (in_fp=1,
// funct3=010) legal; without it every in_fp=1 request is dropped.
module inst_s_enc
  import inst_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic        in_fp,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [11:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        err_illegal,
  output logic [7:0]  illegal_cnt
);

  req_kind_e   kind;
  logic        accept, push, drop, pop;
  logic        full, empty;
  logic [31:0] word;
  logic [63:0] head;
  logic [31:0] addr_cnt_q, addr_cnt_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  // Classify the incoming request as integer store, FP store or illegal.
  always_comb begin
    kind = REQ_ILLEGAL;
    if (!in_fp) begin
      if (in_funct3 == F3_SB || in_funct3 == F3_SH || in_funct3 == F3_SW)
        kind = REQ_INT;
    end else begin
`ifdef INST_S_ENC_FSW_EN
      if (in_funct3 == F3_SW) kind = REQ_FP;
`else
      kind = REQ_ILLEGAL;
`endif
    end
  end

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (kind != REQ_ILLEGAL);
  assign drop     = accept && (kind == REQ_ILLEGAL);
  assign pop      = out_valid && out_ready;
  assign word     = s_pack(in_imm, in_rs2, in_rs1, in_funct3,
                           (kind == REQ_FP) ? OPCODE_STORE_FP : OPCODE_STORE);

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   ({word, addr_cnt_q}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Head is gated to zero while empty so stale storage never reaches the port.
  assign out_valid   = !empty;
  assign out_word    = empty ? '0 : head[63:32];
  assign out_addr    = empty ? '0 : head[31:0];
  assign err_illegal = err_q;
  assign illegal_cnt = cnt_q;

  // Address counter, error pulse and saturating drop counter next-state.
  always_comb begin
    addr_cnt_d = addr_cnt_q;
    err_d      = drop;
    cnt_d      = cnt_q;
    if (push) addr_cnt_d = addr_cnt_q + 32'd4;
    if (drop && cnt_q != '1) cnt_d = cnt_q + 8'd1;
  end

  // Encoder state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_cnt_q <= BASE_ADDR;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      addr_cnt_q <= addr_cnt_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: doc/inst_s_enc.md
Name: inst_s_enc

Overview:
Sequential S-type instruction encoder, the inverse of the S-type field decoder. Accepts store requests (width code, base register, source register, 12-bit signed offset) over a valid/ready handshake. Packs each legal request into a 32-bit RV32I store word, tags it with an incrementing instruction-memory address and buffers it in a small FIFO. Used by the program loader and test harness to emit store instructions into instruction memory.

Parameters:
DEPTH, 4, output FIFO entries (power of two, >=2)
BASE_ADDR, 32'h0000_0000, address tagged on the first emitted word after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  encoder can accept a request
in_funct3  in  3  store width: 000 SB, 001 SH, 010 SW
in_fp  in  1  request FSW (floating-point store) instead of an integer store
in_rs1  in  5  base register
in_rs2  in  5  source register
in_imm  in  12  signed byte offset
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes the head
out_word  out  32  encoded instruction
out_addr  out  32  instruction-memory address of out_word
err_illegal  out  1  one-cycle pulse when a request is dropped as illegal
illegal_cnt  out  8  count of dropped requests, saturates at 8'hFF

Behaviour:
- Encoding: word[31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0], [6:0]=0100011 (STORE), or 0100111 (STORE-FP) when in_fp=1.
- Legal requests: in_fp=0 with funct3 in {000,001,010}; in_fp=1 with funct3=010 (macro-dependent, see Optional Feature). All other requests are illegal.
- Accept: a request is accepted when in_valid && in_ready. in_ready = !full. There is no same-cycle bypass when the FIFO is full, so in_ready stays 0 on a full FIFO even if out_ready=1.
- Legal accept:
  - Push {word, addr_cnt} into the FIFO.
  - addr_cnt increments by 4, wrapping modulo 2^32.
  - Latency: out_valid rises the cycle after acceptance when the FIFO was empty.
- Illegal accept:
  - Nothing is pushed and addr_cnt is unchanged.
  - err_illegal=1 for exactly the next cycle.
  - illegal_cnt increments, holding at 8'hFF.
- Pop: on out_valid && out_ready. out_word and out_addr hold stable while out_valid && !out_ready.
- Simultaneous push and pop:
  - On a non-empty, non-full FIFO, occupancy is unchanged.
  - On an empty FIFO, the pop is ignored (out_valid=0) and the push lands.
- Pointers: wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- Reset (rst_n=0 at an edge), including mid-stream:
  - FIFO is flushed; out_valid=0 and in_ready=1 on the cycle after release.
  - out_word=0, out_addr=0, err_illegal=0, illegal_cnt=0.
  - addr_cnt=BASE_ADDR.
  - Requests presented during reset are not accepted.

Optional Feature:
Macro INST_S_ENC_FSW_EN.
- Defined: in_fp=1 with funct3=010 is legal and encodes with opcode 0100111.
- Undefined: every in_fp=1 request is illegal (dropped, err_illegal pulse, counter increment). The in_fp port remains present.

Decomposition:
- Shared package/include inst_pkg:
  - OPCODE_STORE=7'b0100011, OPCODE_STORE_FP=7'b0100111
  - F3_SB=3'b000, F3_SH=3'b001, F3_SW=3'b010
  - S-type field bit-position constants, shared with the decoder
- Sub-module inst_fifo: parameterised DEPTH/WIDTH synchronous FIFO with push/pop/full/empty. The encoder instantiates it with WIDTH=64.

Test Plan:
- SW encode: reset, then present funct3=010, rs1=2, rs2=5, imm=8 -> next cycle out_valid=1, out_word=0x00512423, out_addr=BASE_ADDR.
- SB with negative offset: funct3=000, rs1=3, rs2=1, imm=12'hFFF -> out_word=0xFE118FA3. Then issue a second SW -> out_addr=BASE_ADDR+4.
- Backpressure: hold out_ready=0 and push 5 legal requests (DEPTH=4) -> in_ready=0 after the 4th, 5th stalls. Then pulse out_ready -> words drain in order and addresses are consecutive multiples of 4.
- Illegal request: funct3=011, in_fp=0 -> err_illegal pulses for one cycle, illegal_cnt=1, no FIFO entry, next legal word reuses the un-incremented address. After 300 illegal requests -> illegal_cnt=0xFF.
- FSW: in_fp=1, funct3=010, rs1=10, rs2=2, imm=4 -> with INST_S_ENC_FSW_EN defined, out_word=0x00252227. Without the macro, err_illegal pulses and nothing is emitted.
- Reset mid-stream: with 3 entries queued, assert rst_n=0 for one cycle -> out_valid=0, illegal_cnt=0, and the next legal word gets out_addr=BASE_ADDR.
